tmp101_poll_scheduler: RTL and testbench

TMP101_POLL_SCHEDULER -- requirements
Module: tmp101_poll_scheduler

---
 rtl/tmp101_poll_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_tmp101_poll_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tmp101_poll_scheduler.sv
// Polls two TMP101 sensors in turn through an external I2C read unit and keeps the latest reading per sensor.
// Optional TMP101_FAHRENHEIT_EN converts captured Celsius bytes to clamped Fahrenheit (0..99).
module tmp101_poll_scheduler #(
    parameter logic [31:0] POLL_CYCLES    = 32'd50000000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
    parameter logic [7:0]  ADDR0          = 8'h91,
    parameter logic [7:0]  ADDR1          = 8'h93
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       done_i,
    input  logic [7:0] received_data_i,
    output logic       start_o,
    output logic [7:0] first_byte_o,
    output logic [7:0] temp0_o,
    output logic [7:0] temp1_o,
    output logic       valid0_o,
    output logic       valid1_o,
    output logic       error0_o,
    output logic       error1_o,
    output logic       busy_o,
    output logic       round_done_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_START0 = 3'd2,
        S_BUSY0  = 3'd3,
        S_START1 = 3'd4,
        S_BUSY1  = 3'd5
    } state_t;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    state_t      state_q, state_d;
    logic        done_q;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] poll_q, poll_d;
    logic        abort_q, abort_d;
    logic        round_done_q, round_done_d;
    logic [7:0]  temp0_q, temp0_d, temp1_q, temp1_d;
    logic        valid0_q, valid0_d, valid1_q, valid1_d;
    logic        error0_q, error0_d, error1_q, error1_d;

    logic        in_busy, in_xfer, done_rise, tmo_hit, poll_hit;
    logic        complete, timeout, finish, stop;
    logic [7:0]  conv_temp;

    function automatic logic [7:0] to_temp(input logic [7:0] c);
`ifdef TMP101_FAHRENHEIT_EN
        logic signed [11:0] cs;
        logic signed [11:0] f;
        cs = {{4{c[7]}}, c};
        // Signed division truncates toward zero, which is the rounding we want.
        f  = (cs * 12'sd9) / 12'sd5 + 12'sd32;
        if (f < 12'sd0) begin
            return 8'd0;
        end else if (f > 12'sd99) begin
            return 8'd99;
        end else begin
            return f[7:0];
        end
`else
        return c;
`endif
    endfunction

    assign conv_temp = to_temp(received_data_i);

    assign in_busy   = (state_q == S_BUSY0) || (state_q == S_BUSY1);
    assign in_xfer   = in_busy || (state_q == S_START0) || (state_q == S_START1);
    assign done_rise = done_i && !done_q;
    assign tmo_hit   = (tmo_q >= (TIMEOUT_CYCLES - 32'd1));
    assign poll_hit  = (poll_q >= (POLL_CYCLES - 32'd1));
    // An edge on the limit cycle wins over the timeout.
    assign complete  = in_busy && done_rise;
    assign timeout   = in_busy && !done_rise && tmo_hit;
    assign finish    = complete || timeout;
    assign stop      = abort_q || !enable_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (enable_i) state_d = S_START0;
            S_WAIT: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (poll_hit) begin
                    state_d = S_START0;
                end
            end
            S_START0: state_d = S_BUSY0;
            S_BUSY0:  if (finish) state_d = stop ? S_IDLE : S_START1;
            S_START1: state_d = S_BUSY1;
            S_BUSY1:  if (finish) state_d = stop ? S_IDLE : S_WAIT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        start_o      = (state_q == S_START0) || (state_q == S_START1);
        busy_o       = in_xfer;
        first_byte_o = ((state_q == S_START1) || (state_q == S_BUSY1)) ? ADDR1 : ADDR0;
    end

    always_comb begin
        tmo_d        = 32'd0;
        poll_d       = 32'd0;
        temp0_d      = temp0_q;
        temp1_d      = temp1_q;
        valid0_d     = valid0_q;
        valid1_d     = valid1_q;
        error0_d     = error0_q;
        error1_d     = error1_q;
        round_done_d = 1'b0;
        abort_d      = 1'b0;

        if (in_busy) begin
            tmo_d = (tmo_q == CNT_MAX) ? tmo_q : tmo_q + 32'd1;
        end
        if (state_q == S_WAIT) begin
            poll_d = (poll_q == CNT_MAX) ? poll_q : poll_q + 32'd1;
        end
        // Remember an Enable drop until the current sensor finishes.
        if (state_d != S_IDLE && state_d != S_WAIT) begin
            abort_d = abort_q || (in_xfer && !enable_i);
        end

        if (state_q == S_BUSY0) begin
            if (complete) begin
                temp0_d  = conv_temp;
                valid0_d = 1'b1;
            end else if (timeout) begin
                valid0_d = 1'b0;
                error0_d = 1'b1;
            end
        end
        if (state_q == S_BUSY1) begin
            if (complete) begin
                temp1_d  = conv_temp;
                valid1_d = 1'b1;
            end else if (timeout) begin
                valid1_d = 1'b0;
                error1_d = 1'b1;
            end
            round_done_d = finish && !stop;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q       <= 1'b0;
            tmo_q        <= 32'd0;
            poll_q       <= 32'd0;
            abort_q      <= 1'b0;
            round_done_q <= 1'b0;
            temp0_q      <= 8'd0;
            temp1_q      <= 8'd0;
            valid0_q     <= 1'b0;
            valid1_q     <= 1'b0;
            error0_q     <= 1'b0;
            error1_q     <= 1'b0;
        end else begin
            done_q       <= done_i;
            tmo_q        <= tmo_d;
            poll_q       <= poll_d;
            abort_q      <= abort_d;
            round_done_q <= round_done_d;
            temp0_q      <= temp0_d;
            temp1_q      <= temp1_d;
            valid0_q     <= valid0_d;
            valid1_q     <= valid1_d;
            error0_q     <= error0_d;
            error1_q     <= error1_d;
        end
    end

    assign temp0_o      = temp0_q;
    assign temp1_o      = temp1_q;
    assign valid0_o     = valid0_q;
    assign valid1_o     = valid1_q;
    assign error0_o     = error0_q;
    assign error1_o     = error1_q;
    assign round_done_o = round_done_q;

endmodule

// File: tb/tb_tmp101_poll_scheduler.sv
// Directed bench for tmp101_poll_scheduler with POLL_CYCLES=10, TIMEOUT_CYCLES=20.
module tb_tmp101_poll_scheduler;

`ifdef TMP101_FAHRENHEIT_EN
    localparam bit FAHR = 1'b1;
`else
    localparam bit FAHR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       done;
    logic [7:0] rdata;
    logic       start;
    logic [7:0] first_byte;
    logic [7:0] temp0, temp1;
    logic       valid0, valid1, error0, error1, busy, round_done;

    int n_vec = 0;
    int n_err = 0;

    tmp101_poll_scheduler #(
        .POLL_CYCLES   (32'd10),
        .TIMEOUT_CYCLES(32'd20),
        .ADDR0         (8'h91),
        .ADDR1         (8'h93)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .done_i         (done),
        .received_data_i(rdata),
        .start_o        (start),
        .first_byte_o   (first_byte),
        .temp0_o        (temp0),
        .temp1_o        (temp1),
        .valid0_o       (valid0),
        .valid1_o       (valid1),
        .error0_o       (error0),
        .error1_o       (error1),
        .busy_o         (busy),
        .round_done_o   (round_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] f0;
        logic [7:0] f1;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] expt(input logic [7:0] raw, input logic [7:0] f);
        return FAHR ? f : raw;
    endfunction

    // Called in the Start cycle: answers after dly cycles with a one-cycle DONE pulse.
    task automatic reply(input logic [7:0] d, input int dly);
        repeat (dly) tick();
        done  = 1'b1;
        rdata = d;
        tick();
        done  = 1'b0;
    endtask

    // Called in the RoundDone cycle: counts cycles up to the next Start.
    task automatic gap_to_start(input string name);
        int gap = 0;
        int rd  = 0;
        while (!start && gap < 40) begin
            tick();
            gap++;
            if (round_done) rd++;
        end
        check({name, "_gap"}, gap, 10);
        check({name, "_extra_rounddone"}, rd, 0);
    endtask

    // Called in a Start cycle: counts cycles to the following Start.
    task automatic cycles_to_next_start(output int k);
        k = 0;
        tick();
        k++;
        while (!start && k < 60) begin
            tick();
            k++;
        end
    endtask

    initial begin
        int k;
        int starts;
        int rds;

        vecs[0] = '{d0: 8'h19, d1: 8'h19, f0: 8'd77, f1: 8'd77};
        vecs[1] = '{d0: 8'hEC, d1: 8'h32, f0: 8'd0,  f1: 8'd99};
        vecs[2] = '{d0: 8'h00, d1: 8'h7F, f0: 8'd32, f1: 8'd99};
        vecs[3] = '{d0: 8'h80, d1: 8'hFF, f0: 8'd0,  f1: 8'd31};
        vecs[4] = '{d0: 8'hEF, d1: 8'h0A, f0: 8'd2,  f1: 8'd50};

        rst_n  = 1'b0;
        enable = 1'b0;
        done   = 1'b0;
        rdata  = 8'h00;
        repeat (3) tick();
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_rounddone", round_done, 0);
        check("rst_flags", {valid0, valid1, error0, error1}, 0);
        check("rst_temps", {temp0, temp1}, 0);
        check("rst_firstbyte", first_byte, 8'h91);

        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_no_start", {start, busy}, 0);
        enable = 1'b1;
        tick();
        check("idle_to_start0", start, 1);

        for (int i = 0; i < 5; i++) begin
            check("v_fb0", first_byte, 8'h91);
            reply(vecs[i].d0, 5);
            check("v_start1", start, 1);
            check("v_fb1", first_byte, 8'h93);
            check("v_temp0", temp0, expt(vecs[i].d0, vecs[i].f0));
            check("v_valid0", valid0, 1);
            reply(vecs[i].d1, 5);
            check("v_rounddone", round_done, 1);
            check("v_temp1", temp1, expt(vecs[i].d1, vecs[i].f1));
            check("v_valid1", valid1, 1);
            check("v_busy_wait", busy, 0);
            gap_to_start("v");
        end

        // Sensor 0 silent: timeout after 20 cycles, sensor 1 still polled.
        cycles_to_next_start(k);
        check("to_cycles", k, 21);
        check("to_error0", error0, 1);
        check("to_valid0", valid0, 0);
        check("to_temp0_kept", temp0, expt(vecs[4].d0, vecs[4].f0));
        check("to_fb1", first_byte, 8'h93);
        reply(8'h14, 5);
        check("to_temp1", temp1, expt(8'h14, 8'd68));
        check("to_valid1", valid1, 1);
        check("to_error1", error1, 0);
        check("to_rounddone", round_done, 1);
        gap_to_start("to");

        // DONE edge on the timeout-limit cycle counts as completion.
        repeat (20) tick();
        done  = 1'b1;
        rdata = 8'h0A;
        tick();
        done  = 1'b0;
        check("lim_start1", start, 1);
        check("lim_valid0", valid0, 1);
        check("lim_temp0", temp0, expt(8'h0A, 8'd50));
        check("lim_error0_sticky", error0, 1);
        reply(8'h19, 5);
        check("lim_rounddone", round_done, 1);

        // DONE held high through Start: no edge, so timeout.
        done  = 1'b1;
        rdata = 8'h55;
        gap_to_start("held");
        cycles_to_next_start(k);
        check("held_cycles", k, 21);
        check("held_valid0", valid0, 0);
        check("held_temp0", temp0, expt(8'h0A, 8'd50));
        done = 1'b0;
        reply(8'h19, 5);
        check("held_rounddone", round_done, 1);
        gap_to_start("held2");

        // Enable drops in BUSY0: finish sensor 0, then idle.
        repeat (2) tick();
        enable = 1'b0;
        repeat (3) tick();
        done  = 1'b1;
        rdata = 8'h05;
        tick();
        done  = 1'b0;
        check("abort_temp0", temp0, expt(8'h05, 8'd41));
        check("abort_busy", busy, 0);
        starts = 0;
        rds    = 0;
        for (int c = 0; c < 30; c++) begin
            if (start) starts++;
            if (round_done) rds++;
            tick();
        end
        check("abort_no_start", starts, 0);
        check("abort_no_rounddone", rds, 0);
        check("abort_idle_busy", busy, 0);

        // Enable drop in WAIT returns to IDLE on the next cycle.
        enable = 1'b1;
        tick();
        check("reen_start", start, 1);
        reply(8'h19, 5);
        reply(8'h19, 5);
        check("reen_rounddone", round_done, 1);
        repeat (2) tick();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        check("wait_drop_restart", start, 1);

        // Asynchronous reset in the Start cycle, with DONE in flight.
        done = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_start", start, 0);
        check("arst_busy", busy, 0);
        check("arst_flags", {valid0, valid1, error0, error1, round_done}, 0);
        check("arst_temps", {temp0, temp1}, 0);
        check("arst_fb", first_byte, 8'h91);
        repeat (2) tick();
        rst_n = 1'b1;
        k = 0;
        while (!start && k < 20) begin
            tick();
            k++;
        end
        check("arst_restart", start, 1);
        check("arst_restart_fb", first_byte, 8'h91);
        repeat (5) tick();
        check("arst_done_ignored", valid0, 0);
        done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
